paddle_ctrl_multi: RTL and testbench

Parametrised per-frame paddle controller for the Pong game core. It generalises the fixed two-player, fixed-speed button handling to NUM_PLAYERS paddles. Each paddle can be button-driven or AI-tracked. Button inputs are synchronised, speed is latched once per frame with a fallback default, and all paddle positions are updated sequentially through one shared clamp adder. It sits between the top-level pin wrapper and the renderer/collision logic, which consume paddle_y.

---
 rtl/paddle_ctrl_multi.sv | 140 ++++++++++++++
 tb/tb_paddle_ctrl_multi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl_multi.sv
// Per-frame paddle controller for N players, button or AI driven.
// One shared clamp adder walks the paddles one per cycle after frame_tick.
module paddle_ctrl_multi #(
  parameter int NUM_PLAYERS   = 2,
  parameter int SPEED_W       = 4,
  parameter int POS_W         = 10,
  parameter int FIELD_H       = 480,
  parameter int PADDLE_H      = 64,
  parameter int DEFAULT_SPEED = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic                         force_fallback,
  input  logic [SPEED_W-1:0]           speed_cfg,
  input  logic [NUM_PLAYERS-1:0]       ai_en,
  input  logic [POS_W-1:0]             ball_y,
  input  logic [NUM_PLAYERS-1:0]       btn_up,
  input  logic [NUM_PLAYERS-1:0]       btn_down,
  output logic [NUM_PLAYERS*POS_W-1:0] paddle_y,
  output logic [SPEED_W-1:0]           speed_active,
  output logic                         busy,
  output logic                         overrun
);

  localparam int SW    = POS_W + 2;
  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int YMAX  = FIELD_H - PADDLE_H;
  localparam int Y0    = YMAX / 2;

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t state, state_nxt;

  logic [NUM_PLAYERS-1:0] sync_up [SYNC_STAGES];
  logic [NUM_PLAYERS-1:0] sync_dn [SYNC_STAGES];
  logic [NUM_PLAYERS-1:0] lat_up, lat_dn;
  logic [IDX_W-1:0]       idx;
  logic [POS_W-1:0]       pos [NUM_PLAYERS];
  logic                   last;
  logic                   start;

  logic [POS_W-1:0]       cur_y, new_y;
  logic signed [SW-1:0]   y_s, s_s, c_s, b_s, d_s, st_s, nxt_s;
  logic                   go_up, go_dn;

  assign last  = (idx == IDX_W'(NUM_PLAYERS - 1));
  assign start = (state == IDLE) && frame_tick;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (frame_tick) state_nxt = UPDATE;
      UPDATE: if (last)       state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == UPDATE);
  end

  // shared step/clamp datapath for the player at idx
  always_comb begin
    cur_y = pos[idx];
    y_s   = $signed(SW'(cur_y));
    s_s   = $signed(SW'(speed_active));
    c_s   = y_s + $signed(SW'(PADDLE_H / 2));
    b_s   = $signed(SW'(ball_y));
    d_s   = (b_s > c_s) ? (b_s - c_s) : (c_s - b_s);
    go_up = 1'b0;
    go_dn = 1'b0;
    st_s  = s_s;
    if (ai_en[idx]) begin
      st_s  = (d_s < s_s) ? d_s : s_s;
      go_up = (b_s < c_s);
      go_dn = (b_s > c_s);
    end else begin
      go_up = lat_up[idx] && !lat_dn[idx];
      go_dn = lat_dn[idx] && !lat_up[idx];
    end
    nxt_s = y_s;
    if (go_up) nxt_s = y_s - st_s;
    if (go_dn) nxt_s = y_s + st_s;
    if (nxt_s < 0)
      nxt_s = '0;
    else if (nxt_s > $signed(SW'(YMAX)))
      nxt_s = $signed(SW'(YMAX));
    new_y = nxt_s[POS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_up[k] <= '0;
        sync_dn[k] <= '0;
      end
      lat_up       <= '0;
      lat_dn       <= '0;
      idx          <= '0;
      speed_active <= SPEED_W'(DEFAULT_SPEED);
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++)
        pos[i] <= POS_W'(Y0);
    end else begin
      sync_up[0] <= btn_up;
      sync_dn[0] <= btn_down;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_up[k] <= sync_up[k-1];
        sync_dn[k] <= sync_dn[k-1];
      end
      if (start) begin
        lat_up       <= sync_up[SYNC_STAGES-1];
        lat_dn       <= sync_dn[SYNC_STAGES-1];
        speed_active <= force_fallback ? SPEED_W'(DEFAULT_SPEED)
                                       : speed_cfg;
        idx          <= '0;
      end
      if (state == UPDATE) begin
        pos[idx] <= new_y;
        idx      <= last ? '0 : idx + 1'b1;
        if (frame_tick) overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    paddle_y = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      paddle_y[i*POS_W +: POS_W] = pos[i];
  end

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// Directed bench for paddle_ctrl_multi with a behavioural frame model.
// Expected frames are queued at tick time and popped when busy drops.
module tb_paddle_ctrl_multi;

  localparam int NP = 2;

  logic          clk = 0;
  logic          rst;
  logic          frame_tick;
  logic          force_fallback;
  logic [3:0]    speed_cfg;
  logic [NP-1:0] ai_en;
  logic [9:0]    ball_y;
  logic [NP-1:0] btn_up;
  logic [NP-1:0] btn_down;
  logic [19:0]   paddle_y;
  logic [3:0]    speed_active;
  logic          busy;
  logic          overrun;

  paddle_ctrl_multi dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .force_fallback(force_fallback), .speed_cfg(speed_cfg),
    .ai_en(ai_en), .ball_y(ball_y), .btn_up(btn_up),
    .btn_down(btn_down), .paddle_y(paddle_y),
    .speed_active(speed_active), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] py;
    logic [3:0]  sp;
  } exp_t;

  exp_t q[$];
  int   my [NP];
  int   ms;
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int step(input int y, input int s, input bit ai,
                              input bit u, input bit d, input int b);
    int c, st, r;
    r = y;
    if (ai) begin
      c = y + 32;
      if (b < c) begin
        st = (c - b < s) ? c - b : s;
        r  = y - st;
      end else if (b > c) begin
        st = (b - c < s) ? b - c : s;
        r  = y + st;
      end
    end else if (u && !d) r = y - s;
    else if (d && !u)     r = y + s;
    if (r < 0)   r = 0;
    if (r > 416) r = 416;
    return r;
  endfunction

  function automatic logic [19:0] pack();
    logic [19:0] p;
    for (int i = 0; i < NP; i++) p[i*10 +: 10] = my[i][9:0];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) my[i] = 208;
    ms = 4;
  endtask

  task automatic model_frame();
    exp_t e;
    ms = force_fallback ? 4 : int'(speed_cfg);
    for (int i = 0; i < NP; i++)
      my[i] = step(my[i], ms, ai_en[i], btn_up[i], btn_down[i],
                   int'(ball_y));
    e.py = pack();
    e.sp = 4'(ms);
    q.push_back(e);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int pre);
    int   cnt;
    exp_t e;
    cnt = pre;
    for (int k = 0; k < 20 && busy; k++) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, cnt, NP);
    chk({tag, "_busy_low"}, busy, 0);
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, "_paddle_y"}, paddle_y, e.py);
      chk({tag, "_speed"}, speed_active, e.sp);
    end
  endtask

  task automatic tick(input string tag);
    model_frame();
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    wait_done(tag, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; frame_tick = 0; force_fallback = 0; speed_cfg = 0;
    ai_en = 0; ball_y = 0; btn_up = 0; btn_down = 0;
    model_reset();
    do_reset();
    chk("rst_paddle_y", paddle_y, {10'd208, 10'd208});
    chk("rst_speed", speed_active, 4);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    speed_cfg = 7; btn_up = 2'b01; settle();
    for (int i = 0; i < 3; i++) tick("up7");
    chk("up7_p0_187", paddle_y[9:0], 187);
    chk("up7_p1_208", paddle_y[19:10], 208);

    btn_up = 0; btn_down = 2'b10; speed_cfg = 15; settle();
    for (int i = 0; i < 30; i++) begin
      tick("down15");
      assert (paddle_y[19:10] <= 10'd416) else begin
        errs++;
        $error("FAIL down15_bound observed=%0d expected<=416",
               paddle_y[19:10]);
      end
    end
    chk("down15_p1_416", paddle_y[19:10], 416);

    do_reset();
    btn_down = 0; btn_up = 2'b10; speed_cfg = 11; settle();
    for (int i = 0; i < 18; i++) tick("up11");
    chk("up11_p1_10", paddle_y[19:10], 10);
    speed_cfg = 15;
    tick("up_clamp");
    chk("up_clamp_p1_0", paddle_y[19:10], 0);

    do_reset();
    btn_up = 0; speed_cfg = 4; ai_en = 2'b01; ball_y = 250; settle();
    tick("ai_down");
    chk("ai_p0_212", paddle_y[9:0], 212);
    ball_y = 243;
    tick("ai_up");
    chk("ai_p0_211", paddle_y[9:0], 211);
    ai_en = 0;

    do_reset();
    @(negedge clk) btn_up = 2'b11;
    @(negedge clk) btn_up = 2'b00;
    settle();
    tick("pulse");
    chk("pulse_no_move", paddle_y, {10'd208, 10'd208});
    btn_up = 2'b11; btn_down = 2'b11; settle();
    tick("both");
    chk("both_no_move", paddle_y, {10'd208, 10'd208});
    btn_up = 0; btn_down = 0;
    force_fallback = 1; speed_cfg = 0;
    tick("fallback");
    chk("fallback_speed4", speed_active, 4);
    force_fallback = 0;

    speed_cfg = 5; btn_down = 2'b01; settle();
    model_frame();
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    wait_done("overrun", 1);
    chk("overrun_set", overrun, 1);
    chk("overrun_p0_213", paddle_y[9:0], 213);
    tick("overrun_sticky");
    chk("overrun_sticky", overrun, 1);

    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    chk("mid_busy", busy, 1);
    rst = 1;
    @(negedge clk) rst = 0;
    model_reset();
    chk("mid_rst_paddle_y", paddle_y, {10'd208, 10'd208});
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_speed", speed_active, 4);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
